// File: rtl/fetch_pkg.sv
// Shared defaults and entry type for the instruction prefetch queue.
// The optional FETCH_QUEUE_BYPASS_EN feature is selected in fetch_queue.sv.
package fetch_pkg;

    localparam int FQ_DEPTH   = 4;
    localparam int FQ_ADDR_W  = 6;
    localparam int FQ_INSTR_W = 32;
    localparam int FQ_PTR_W   = $clog2(FQ_DEPTH);

    typedef struct packed {
        logic [FQ_INSTR_W-1:0] instr;
        logic [FQ_ADDR_W-1:0]  pc;
    } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Circular entry RAM for the fetch queue: one write port at the tail, one
// asynchronous read port at the head. Pointers and count live in the parent.
module fq_storage #(
    parameter int DEPTH = fetch_pkg::FQ_DEPTH,
    parameter int WIDTH = fetch_pkg::FQ_INSTR_W + fetch_pkg::FQ_ADDR_W,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers DEPTH words, and
// hands them to the ALU over valid/ready. Define FETCH_QUEUE_BYPASS_EN for zero-latency forwarding.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH   = FQ_DEPTH,
    parameter int ADDR_W  = FQ_ADDR_W,
    parameter int INSTR_W = FQ_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               ins_valid,
    input  logic               ins_ready,
    output logic [INSTR_W-1:0] ins_data,
    output logic [ADDR_W-1:0]  ins_pc,
    output logic               full
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = INSTR_W + ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  pc;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [ENTRY_W-1:0] rd_entry;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;

    logic q_valid;
    logic bypass;
    logic pop;
    logic q_pop;
    logic bypass_take;
    logic push;
    logic advance;

    fq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_ptr  (tail),
        .wr_data ({imem_data, pc}),
        .rd_ptr  (head),
        .rd_data (rd_entry)
    );

    assign head_instr = rd_entry[ENTRY_W-1 -: INSTR_W];
    assign head_pc    = rd_entry[ADDR_W-1:0];
    assign q_valid    = (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue: present the word being fetched this cycle directly.
    assign bypass    = !q_valid && !redirect;
    assign ins_valid = q_valid | bypass;
    assign ins_data  = q_valid ? head_instr : (bypass ? imem_data : '0);
    assign ins_pc    = q_valid ? head_pc    : (bypass ? pc        : '0);
`else
    assign bypass    = 1'b0;
    assign ins_valid = q_valid;
    assign ins_data  = q_valid ? head_instr : '0;
    assign ins_pc    = q_valid ? head_pc    : '0;
`endif

    assign pop         = ins_valid & ins_ready;
    assign q_pop       = pop & q_valid;
    assign bypass_take = bypass & ins_ready;
    // A full queue still fetches when the head leaves in the same cycle.
    assign push        = !redirect && ((count < CNT_MAX) || q_pop) && !bypass_take;
    assign advance     = push | bypass_take;

    assign imem_addr = pc;
    assign full      = (count == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= '0;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (redirect) begin
            pc    <= redirect_pc;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push)    tail <= tail + PTR_W'(1);
            if (q_pop)   head <= head + PTR_W'(1);
            if (advance) pc   <= pc + ADDR_W'(1);
            case ({push, q_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default build, no bypass).
// Instruction memory model: word[a] = a + 100.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [5:0]  redirect_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_data;
    logic [5:0]  ins_pc;
    logic        full;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_data    (ins_data),
        .ins_pc      (ins_pc),
        .full        (full)
    );

    assign imem_data = 32'(imem_addr) + 32'd100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        ins_ready   = 1'b1;
        step();
        step();
        check("rst_valid", ins_valid, 0);
        check("rst_addr",  imem_addr, 0);
        check("rst_full",  full, 0);
        check("rst_data",  ins_data, 0);
        check("rst_pc",    ins_pc, 0);

        // Streaming with ready high: one instruction per cycle, never full.
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("strm_valid%0d", i), ins_valid, 1);
            check($sformatf("strm_pc%0d", i),    ins_pc, i);
            check($sformatf("strm_data%0d", i),  ins_data, 100 + i);
            check($sformatf("strm_addr%0d", i),  imem_addr, i + 1);
            check($sformatf("strm_full%0d", i),  full, 0);
        end

        // Stall: fill in 4 cycles, then hold.
        ins_ready = 1'b0;
        pulse_reset();
        check("fill_addr0", imem_addr, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("fill_addr%0d", k), imem_addr, (k < 4) ? k : 4);
            check($sformatf("fill_full%0d", k), full, (k >= 4) ? 1 : 0);
            check($sformatf("fill_pc%0d", k),   ins_pc, 0);
            check($sformatf("fill_data%0d", k), ins_data, 100);
        end
        // No combinational path from ins_ready to the outputs.
        ins_ready = 1'b1;
        #1;
        check("comb_pc",    ins_pc, 0);
        check("comb_full",  full, 1);
        check("comb_valid", ins_valid, 1);
        // Full plus pop: head advances and the fetch continues, count stays at DEPTH.
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("drain_pc%0d", k),   ins_pc, k);
            check($sformatf("drain_data%0d", k), ins_data, 100 + k);
            check($sformatf("drain_full%0d", k), full, 1);
            check($sformatf("drain_addr%0d", k), imem_addr, 4 + k);
        end

        // Redirect with three entries queued.
        ins_ready = 1'b0;
        pulse_reset();
        step(); step(); step();
        check("pre_redir_addr", imem_addr, 3);
        check("pre_redir_pc",   ins_pc, 0);
        redirect    = 1'b1;
        redirect_pc = 6'd40;
        step();
        redirect  = 1'b0;
        ins_ready = 1'b1;
        check("redir_valid", ins_valid, 0);
        check("redir_addr",  imem_addr, 40);
        check("redir_pc",    ins_pc, 0);
        check("redir_data",  ins_data, 0);
        check("redir_full",  full, 0);
        step();
        check("redir_valid1", ins_valid, 1);
        check("redir_pc1",    ins_pc, 40);
        check("redir_data1",  ins_data, 140);
        step();
        check("redir_pc2",    ins_pc, 41);
        check("redir_data2",  ins_data, 141);

        // Redirect near the top of the address space: PC wraps 63 -> 0.
        redirect    = 1'b1;
        redirect_pc = 6'd62;
        step();
        redirect = 1'b0;
        check("wrap_valid0", ins_valid, 0);
        check("wrap_addr0",  imem_addr, 62);
        begin
            int exp_pc [4] = '{62, 63, 0, 1};
            for (int k = 0; k < 4; k++) begin
                step();
                check($sformatf("wrap_pc%0d", k),   ins_pc, exp_pc[k]);
                check($sformatf("wrap_data%0d", k), ins_data, exp_pc[k] + 100);
                check($sformatf("wrap_addr%0d", k), imem_addr, (exp_pc[k] + 1) % 64);
            end
        end

        // Asynchronous reset mid-stream with two entries queued.
        ins_ready = 1'b0;
        pulse_reset();
        step(); step();
        check("mid_valid_pre", ins_valid, 1);
        check("mid_addr_pre",  imem_addr, 2);
        reset = 1'b0;
        #1;
        check("mid_valid", ins_valid, 0);
        check("mid_addr",  imem_addr, 0);
        check("mid_full",  full, 0);
        check("mid_pc",    ins_pc, 0);
        check("mid_data",  ins_data, 0);
        reset     = 1'b1;
        ins_ready = 1'b1;
        step();
        check("post_valid", ins_valid, 1);
        check("post_pc",    ins_pc, 0);
        check("post_data",  ins_data, 100);
        check("post_addr",  imem_addr, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000 ns");
        $fatal(1);
    end

endmodule
